// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - load-stream and instruction-memory write bundle
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader writing 32-bit words into instruction memory
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         pc_clear,
  output logic         busy,
  output logic         err
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE} state_t;

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

  state_t                state;
  logic                  len_hi;
  logic [15:0]           n;
  logic [1:0]            byte_cnt;
  logic [23:0]           word;
  logic [ADDR_WIDTH-1:0] index;

  logic        accept;
  logic [15:0] n_full;
  logic        last_word;

  assign accept    = bus.in_valid & bus.in_ready;
  assign n_full    = {bus.in_data, n[7:0]};
  assign last_word = (17'(index) == (17'(n) - 17'd1));

  // Every output is registered and updated together with the state it belongs to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      len_hi         <= 1'b0;
      n              <= '0;
      byte_cnt       <= '0;
      word           <= '0;
      index          <= '0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_hold       <= 1'b0;
      pc_clear       <= 1'b0;
      busy           <= 1'b0;
      err            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LEN;
            err          <= 1'b0;
            index        <= '0;
            len_hi       <= 1'b0;
            bus.in_ready <= 1'b1;
            cpu_hold     <= 1'b1;
            busy         <= 1'b1;
          end
        end

        LEN: begin
          if (accept) begin
            if (!len_hi) begin
              n[7:0] <= bus.in_data;
              len_hi <= 1'b1;
            end else begin
              n[15:8] <= bus.in_data;
              len_hi  <= 1'b0;
              if (n_full == 16'd0) begin
                state        <= DONE;
                bus.in_ready <= 1'b0;
                pc_clear     <= 1'b1;
              end else if ({1'b0, n_full} > DEPTH) begin
                // Oversized image: abort with nothing written and release the CPU.
                state        <= IDLE;
                err          <= 1'b1;
                bus.in_ready <= 1'b0;
                cpu_hold     <= 1'b0;
                busy         <= 1'b0;
              end else begin
                state    <= DATA;
                byte_cnt <= 2'd0;
              end
            end
          end
        end

        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word[7:0]   <= bus.in_data;
              2'd1: word[15:8]  <= bus.in_data;
              2'd2: word[23:16] <= bus.in_data;
              default: begin
                state          <= WRITE;
                bus.in_ready   <= 1'b0;
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= index;
                bus.imem_wdata <= {bus.in_data, word};
              end
            endcase
          end
        end

        WRITE: begin
          bus.imem_we <= 1'b0;
          if (last_word) begin
            state    <= DONE;
            pc_clear <= 1'b1;
          end else begin
            state        <= DATA;
            index        <= index + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            byte_cnt     <= 2'd0;
            bus.in_ready <= 1'b1;
          end
        end

        DONE: begin
          state    <= IDLE;
          pc_clear <= 1'b0;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          bus.imem_we  <= 1'b0;
          pc_clear     <= 1'b0;
          cpu_hold     <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized session bench for imem_loader with a write-queue reference model
module tb_imem_loader;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clock;
  logic reset_n;
  logic start;
  logic cpu_hold, pc_clear, busy, err;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .pc_clear (pc_clear),
    .busy     (busy),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic [31:0]   sess_words [0:DEPTH-1];

  int            pc_seen  = 0;
  int            we_count = 0;
  logic [AW-1:0] last_addr  = '0;
  logic [31:0]   last_wdata = '0;
  logic          prev_hs = 1'b0;
  logic          prev_pc = 1'b0;
  bit            noise_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, expv, $time);
    end
  endtask

  // Output monitor: samples just after the falling edge, when both DUT outputs and bench drives are settled.
  always begin
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    @(negedge clock);
    #1;
    if (!reset_n) begin
      prev_hs    = 1'b0;
      prev_pc    = 1'b0;
      last_addr  = '0;
      last_wdata = '0;
    end else begin
      if (bus.imem_we) begin
        check("we_after_last_byte", {31'd0, prev_hs}, 32'd1);
        check("we_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        check("we_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        if (exp_addr.size() == 0) begin
          check("we_unexpected", 32'd1, 32'd0);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          check("we_addr", {24'd0, bus.imem_addr}, {24'd0, ea});
          check("we_data", bus.imem_wdata, ed);
        end
        last_addr  = bus.imem_addr;
        last_wdata = bus.imem_wdata;
        we_count++;
      end else begin
        check("addr_hold", {24'd0, bus.imem_addr}, {24'd0, last_addr});
        check("wdata_hold", bus.imem_wdata, last_wdata);
      end
      if (pc_clear) begin
        pc_seen++;
        check("pc_one_cycle", {31'd0, prev_pc}, 32'd0);
        check("pc_not_with_we", {31'd0, bus.imem_we}, 32'd0);
        check("pc_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      end
      check("hold_eq_busy", {31'd0, cpu_hold}, {31'd0, busy});
      prev_hs = bus.in_valid & bus.in_ready;
      prev_pc = pc_clear;
    end
  end

  // Called at a falling edge; returns at the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit jitter);
    int guard = 0;
    if (jitter) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        if (noise_en) start = $urandom_range(0, 1) == 1;
        @(negedge clock);
      end
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    if (noise_en) start = $urandom_range(0, 1) == 1;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clock);
      if (noise_en) start = $urandom_range(0, 1) == 1;
      guard++;
    end
    if (guard >= 100) check("in_ready_timeout", 32'd1, 32'd0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    if (noise_en) start = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_session(input int n, input bit jitter, input bit noise);
    int          pc0 = pc_seen;
    int          we0 = we_count;
    bit          ok_len = (n <= DEPTH);
    logic [15:0] nn = n[15:0];
    if (ok_len)
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(i[AW-1:0]);
        exp_data.push_back(sess_words[i]);
      end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_err_clear", {31'd0, err}, 32'd0);
    check("start_in_ready", {31'd0, bus.in_ready}, 32'd1);
    noise_en = noise;
    send_byte(nn[7:0], jitter);
    send_byte(nn[15:8], jitter);
    if (ok_len)
      for (int i = 0; i < n; i++)
        for (int b = 0; b < 4; b++)
          send_byte(sess_words[i][8*b +: 8], jitter);
    noise_en = 1'b0;
    start    = 1'b0;
    wait_idle();
    @(negedge clock);
    check("sess_err", {31'd0, err}, ok_len ? 32'd0 : 32'd1);
    check("sess_pc_count", pc_seen - pc0, ok_len ? 32'd1 : 32'd0);
    check("sess_write_count", we_count - we0, ok_len ? n : 0);
    check("sess_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("sess_queue_empty", exp_addr.size(), 32'd0);
  endtask

  initial begin
    int n;
    reset_n      = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_we", {31'd0, bus.imem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_pc", {31'd0, pc_clear}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    sess_words[0] = 32'h12345678;
    run_session(1, 1'b0, 1'b0);
    check("single_addr", {24'd0, last_addr}, 32'd0);
    check("single_data", last_wdata, 32'h12345678);

    run_session(0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) sess_words[i] = $urandom;
    run_session(3, 1'b1, 1'b0);
    check("n3_last_addr", {24'd0, last_addr}, 32'd2);

    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) sess_words[i] = $urandom;
      run_session(n, 1'b1, 1'b0);
      check("rand_last_addr", {24'd0, last_addr}, n - 1);
    end

    run_session(257, 1'b0, 1'b0);
    check("err_pc_low", {31'd0, pc_clear}, 32'd0);

    for (int i = 0; i < DEPTH; i++) sess_words[i] = $urandom;
    run_session(DEPTH, 1'b1, 1'b1);
    check("full_last_addr", {24'd0, last_addr}, 32'd255);
    check("full_last_data", last_wdata, sess_words[255]);

    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("arst_we", {31'd0, bus.imem_we}, 32'd0);
    check("arst_hold", {31'd0, cpu_hold}, 32'd0);
    check("arst_pc", {31'd0, pc_clear}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_err", {31'd0, err}, 32'd0);
    check("arst_addr", {24'd0, bus.imem_addr}, 32'd0);
    check("arst_wdata", bus.imem_wdata, 32'd0);
    exp_addr.delete();
    exp_data.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    sess_words[0] = $urandom;
    run_session(1, 1'b1, 1'b0);
    check("post_rst_addr", {24'd0, last_addr}, 32'd0);
    check("post_rst_data", last_wdata, sess_words[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, instruction-memory word-address width (depth 2^ADDR_WIDTH words).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a load session; sampled only in IDLE.
REQ-005 in_data  input  8  load-stream byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts byte; transfer = in_valid & in_ready at rising edge.
REQ-008 imem_we  output  1  instruction-memory write enable, one cycle per word.
REQ-009 imem_addr  output  ADDR_WIDTH  instruction-memory write address.
REQ-010 imem_wdata  output  32  instruction word to write.
REQ-011 cpu_hold  output  1  stalls PC/pipeline while high.
REQ-012 pc_clear  output  1  one-cycle pulse forcing PC to 0 at session end.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 err  output  1  sticky length error; cleared on next accepted start.

Function
REQ-015 States SHALL be IDLE, LEN, DATA, WRITE, DONE.
REQ-016 IDLE: in_ready=0, imem_we=0, cpu_hold=0; start=1 -> LEN next cycle, err cleared, word index cleared to 0.
REQ-017 LEN: in_ready=1; accepts exactly 2 bytes forming a 16-bit word count N, first byte = bits 7:0.
REQ-018 After the 2nd LEN byte: N=0 -> DONE; N>2^ADDR_WIDTH -> err=1, IDLE, no writes; otherwise -> DATA.
REQ-019 DATA: in_ready=1; accepts 4 bytes, little-endian (1st byte -> imem_wdata[7:0], 4th -> [31:24]); after 4th byte -> WRITE.
REQ-020 WRITE: in_ready=0, imem_we=1 for exactly one cycle, imem_addr=word index, imem_wdata=assembled word; latency last byte accepted -> imem_we = 1 cycle.
REQ-021 Leaving WRITE: index==N-1 -> DONE, else index+1 and -> DATA; index never wraps within a session.
REQ-022 DONE: pc_clear=1 for one cycle, cpu_hold=1 during DONE, -> IDLE next cycle (cpu_hold low thereafter).
REQ-023 cpu_hold SHALL be 1 in LEN, DATA, WRITE, DONE; 0 in IDLE, including after err exit.
REQ-024 in_valid low SHALL stall LEN/DATA indefinitely without losing accepted bytes; no timeout.
REQ-025 start asserted while busy SHALL be ignored.
REQ-026 imem_we, pc_clear SHALL never be asserted outside WRITE/DONE respectively.
REQ-027 imem_addr/imem_wdata SHALL hold last value when imem_we=0.

Reset
REQ-028 reset_n low SHALL immediately force IDLE; in_ready, imem_we, cpu_hold, pc_clear, busy, err = 0; imem_addr, imem_wdata, index, N = 0.
REQ-029 Reset mid-session SHALL discard any partial word; no write issued after reset deasserts.
REQ-030 First rising edge after reset_n rises SHALL operate normally from IDLE.

Verification
REQ-031 start; bytes 01 00 78 56 34 12 -> one imem_we, addr 0, wdata 0x12345678, one cycle after last byte; pc_clear pulse; cpu_hold 0 next cycle.
REQ-032 start; bytes 00 00 -> no imem_we, DONE pulse pc_clear, back to IDLE, err=0.
REQ-033 N=3 with in_valid toggled randomly -> writes addr 0,1,2 with correct words, in_ready never high in WRITE.
REQ-034 ADDR_WIDTH=8, bytes 01 01 (N=257) -> err=1, no writes, cpu_hold 0, pc_clear never asserted; next start clears err.
REQ-035 reset_n low after 2 DATA bytes -> all outputs 0 asynchronously; new session N=1 writes addr 0 with fresh word only.
REQ-036 N=256 full load plus start pulses during session -> addresses 0..255 in order, starts ignored, single pc_clear.
